// File: rtl/alu_share_ctrl.sv
// Round-robin front end sharing one combinational ALU between two
// requesters, with a single tagged response channel.
module alu_share_ctrl #(
    parameter int WIDTH = 24,
    parameter int SELW  = 1,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [SELW-1:0]  req0_sel,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [SELW-1:0]  req1_sel,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic [SELW-1:0]  alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_c,
    output logic [CNTW-1:0]  done_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t            state;
    logic              last_grant;
    logic              id_q;
    logic [SELW-1:0]   op_sel;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  res_q;
    logic [CNTW-1:0]   cnt_q;
    logic              in_idle;
    logic              gnt0;
    logic              gnt1;

    // On a tie the requester that did not win last time gets the grant.
    assign in_idle = (state == IDLE) && !rst;
    assign gnt0 = in_idle && req0_valid && (!req1_valid || last_grant);
    assign gnt1 = in_idle && req1_valid && (!req0_valid || !last_grant);

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign resp_valid = (state == RESP) && !rst;
    assign resp_id    = id_q;
    assign resp_data  = res_q;
    assign alu_sel    = op_sel;
    assign alu_a      = op_a;
    assign alu_b      = op_b;
    assign done_cnt   = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            op_sel     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt0) begin
                        op_sel     <= req0_sel;
                        op_a       <= req0_a;
                        op_b       <= req0_b;
                        id_q       <= 1'b0;
                        last_grant <= 1'b0;
                        state      <= EXEC;
                    end else if (gnt1) begin
                        op_sel     <= req1_sel;
                        op_a       <= req1_a;
                        op_b       <= req1_b;
                        id_q       <= 1'b1;
                        last_grant <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    res_q <= alu_c;
                    state <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        cnt_q <= cnt_q + CNTW'(1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural subtract ALU.
// Counter width is reduced so the wrap is reached in four operations.
module tb_alu_share_ctrl;

    localparam int WIDTH = 24;
    localparam int SELW  = 1;
    localparam int CNTW  = 2;

    logic             clk;
    logic             rst;
    logic             req0_valid;
    logic             req0_ready;
    logic [SELW-1:0]  req0_sel;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [SELW-1:0]  req1_sel;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_data;
    logic [SELW-1:0]  alu_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_c;
    logic [CNTW-1:0]  done_cnt;

    int n_chk;
    int n_fail;
    logic [CNTW-1:0] exp_done;

    alu_share_ctrl #(
        .WIDTH(WIDTH),
        .SELW (SELW),
        .CNTW (CNTW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_sel  (req0_sel),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_sel  (req1_sel),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id   (resp_id),
        .resp_data (resp_data),
        .alu_sel   (alu_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c     (alu_c),
        .done_cnt  (done_cnt)
    );

    assign alu_c = (alu_sel == 1'b1) ? alu_a - alu_b : '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(negedge clk);
    endtask

    // Full transaction with resp_ready held high, starting in IDLE.
    task automatic op(input logic eid, input logic [WIDTH-1:0] edata);
        #1;
        chk("grant0", 32'(req0_ready), 32'(eid == 1'b0));
        chk("grant1", 32'(req1_ready), 32'(eid == 1'b1));
        cyc;
        #1;
        chk("exec_valid", 32'(resp_valid), 0);
        chk("exec_rdy", 32'({req0_ready, req1_ready}), 0);
        cyc;
        #1;
        chk("resp_valid", 32'(resp_valid), 1);
        chk("resp_id", 32'(resp_id), 32'(eid));
        chk("resp_data", 32'(resp_data), 32'(edata));
        cyc;
        exp_done = exp_done + 1'b1;
        #1;
        chk("done_cnt", 32'(done_cnt), 32'(exp_done));
        chk("idle_valid", 32'(resp_valid), 0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        exp_done = '0;
        rst = 1'b1;
        resp_ready = 1'b0;
        req0_valid = 1'b1;
        req0_sel = 1'b1;
        req0_a = 24'd10;
        req0_b = 24'd3;
        req1_valid = 1'b1;
        req1_sel = 1'b1;
        req1_a = 24'd1;
        req1_b = 24'd1;

        // Reset: no ready, no response, counter zero.
        cyc;
        #1;
        chk("rst_rdy", 32'({req0_ready, req1_ready}), 0);
        chk("rst_valid", 32'(resp_valid), 0);
        chk("rst_cnt", 32'(done_cnt), 0);
        cyc;

        // Single op from requester 0: 10 - 3.
        rst = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("t1_rdy0", 32'(req0_ready), 1);
        chk("t1_rdy1", 32'(req1_ready), 0);
        cyc;
        req0_valid = 1'b0;
        #1;
        chk("t1_exec_valid", 32'(resp_valid), 0);
        chk("t1_alu_a", 32'(alu_a), 10);
        chk("t1_alu_b", 32'(alu_b), 3);
        chk("t1_alu_sel", 32'(alu_sel), 1);
        cyc;
        #1;
        chk("t1_valid", 32'(resp_valid), 1);
        chk("t1_id", 32'(resp_id), 0);
        chk("t1_data", 32'(resp_data), 7);
        chk("t1_cnt_pre", 32'(done_cnt), 0);
        resp_ready = 1'b1;
        cyc;
        #1;
        chk("t1_cnt", 32'(done_cnt), 1);
        chk("t1_idle", 32'(resp_valid), 0);

        // Both valid from reset: alternate 0,1,0,1; counter wraps.
        rst = 1'b1;
        cyc;
        rst = 1'b0;
        exp_done = '0;
        #1;
        chk("t2_cnt_rst", 32'(done_cnt), 0);
        req0_valid = 1'b1;
        req0_sel = 1'b1;
        req0_a = 24'd100;
        req0_b = 24'd1;
        req1_valid = 1'b1;
        req1_sel = 1'b1;
        req1_a = 24'd50;
        req1_b = 24'd8;
        op(1'b0, 24'd99);
        op(1'b1, 24'd42);
        op(1'b0, 24'd99);
        op(1'b1, 24'd42);
        chk("t6_wrap", 32'(done_cnt), 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Requester 1 alone: negative wrap, then sel=0.
        req1_valid = 1'b1;
        req1_sel = 1'b1;
        req1_a = 24'd3;
        req1_b = 24'd10;
        op(1'b1, 24'hFFFFF9);
        req1_sel = 1'b0;
        op(1'b1, 24'd0);
        req1_valid = 1'b0;

        // Back-pressure held in RESP for five cycles.
        resp_ready = 1'b0;
        req0_valid = 1'b1;
        req0_sel = 1'b1;
        req0_a = 24'd20;
        req0_b = 24'd5;
        #1;
        chk("t4_rdy0", 32'(req0_ready), 1);
        cyc;
        req1_valid = 1'b1;
        req1_sel = 1'b1;
        req1_a = 24'd9;
        req1_b = 24'd4;
        cyc;
        #1;
        chk("t4_valid", 32'(resp_valid), 1);
        chk("t4_data", 32'(resp_data), 15);
        for (int i = 0; i < 5; i++) begin
            cyc;
            #1;
            chk("t4_hold_valid", 32'(resp_valid), 1);
            chk("t4_hold_id", 32'(resp_id), 0);
            chk("t4_hold_data", 32'(resp_data), 15);
            chk("t4_hold_rdy", 32'({req0_ready, req1_ready}), 0);
            chk("t4_hold_cnt", 32'(done_cnt), 32'(exp_done));
        end
        resp_ready = 1'b1;
        cyc;
        exp_done = exp_done + 1'b1;
        #1;
        chk("t4_cnt", 32'(done_cnt), 32'(exp_done));
        chk("t4_after_valid", 32'(resp_valid), 0);
        chk("t4_after_rdy1", 32'(req1_ready), 1);
        chk("t4_after_rdy0", 32'(req0_ready), 0);
        op(1'b1, 24'd5);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Reset while in EXEC drops the op.
        req1_valid = 1'b1;
        req1_sel = 1'b1;
        req1_a = 24'd7;
        req1_b = 24'd2;
        #1;
        chk("t5_rdy1", 32'(req1_ready), 1);
        cyc;
        rst = 1'b1;
        req1_valid = 1'b0;
        cyc;
        rst = 1'b0;
        exp_done = '0;
        #1;
        chk("t5_valid", 32'(resp_valid), 0);
        chk("t5_cnt", 32'(done_cnt), 0);
        for (int i = 0; i < 2; i++) begin
            cyc;
            #1;
            chk("t5_no_resp", 32'(resp_valid), 0);
        end
        req0_valid = 1'b1;
        req0_sel = 1'b1;
        req0_a = 24'd8;
        req0_b = 24'd1;
        req1_valid = 1'b1;
        op(1'b0, 24'd7);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
